// File: rtl/seed_key_requester.sv
// Seed/key requester: sends three 32-bit chaos seeds over a byte UART, then
// collects KEY_BYTES key bytes with an inter-byte timeout.
module seed_key_requester #(
  parameter int KEY_BYTES      = 48,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            seed_x,
  input  logic [31:0]            seed_y,
  input  logic [31:0]            seed_z,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [8*KEY_BYTES-1:0] key,
  output logic                   key_valid,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [5:0]             bytes_rcvd
);

  localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TLAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]      LAST_BYTE = 6'(KEY_BYTES - 1);
  localparam logic [3:0]      LAST_TX   = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_KEY = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } state_t;

  state_t                 r_state;
  logic [87:0]            r_seed_sr;
  logic [3:0]             r_tx_idx;
  logic [7:0]             r_tx_data;
  logic                   r_tx_valid;
  logic [TW-1:0]          r_tcnt;
  logic [8*KEY_BYTES-1:0] r_key;
  logic                   r_key_valid;
  logic                   r_busy;
  logic                   r_timeout_err;
  logic [5:0]             r_bytes_rcvd;

  // Request FSM; r_seed_sr holds the bytes still to be sent after the one on tx_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_seed_sr     <= 88'h0;
      r_tx_idx      <= 4'd0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_tcnt        <= '0;
      r_key         <= '0;
      r_key_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_bytes_rcvd  <= 6'd0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_seed_sr     <= {seed_z, seed_y, seed_x[31:8]};
            r_tx_data     <= seed_x[7:0];
            r_tx_valid    <= 1'b1;
            r_tx_idx      <= 4'd0;
            r_key         <= '0;
            r_key_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_bytes_rcvd  <= 6'd0;
            r_busy        <= 1'b1;
            r_state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (r_tx_valid && tx_ready) begin
            if (r_tx_idx == LAST_TX) begin
              r_tx_valid <= 1'b0;
              r_tcnt     <= '0;
              r_state    <= ST_WAIT_KEY;
            end else begin
              r_tx_idx  <= r_tx_idx + 4'd1;
              r_tx_data <= r_seed_sr[7:0];
              r_seed_sr <= {8'h00, r_seed_sr[87:8]};
            end
          end
        end
        ST_WAIT_KEY: begin
          // A byte on the expiry cycle wins over the timeout.
          if (rx_valid) begin
            for (int j = 0; j < KEY_BYTES; j++) begin
              if (r_bytes_rcvd == 6'(j)) begin
                r_key[8*j +: 8] <= rx_data;
              end
            end
            r_bytes_rcvd <= r_bytes_rcvd + 6'd1;
            r_tcnt       <= '0;
            if (r_bytes_rcvd == LAST_BYTE) begin
              r_state     <= ST_DONE;
              r_key_valid <= 1'b1;
              r_busy      <= 1'b0;
            end
          end else if (r_tcnt == TLAST) begin
            r_state       <= ST_ERR;
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign key         = r_key;
  assign key_valid   = r_key_valid;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign bytes_rcvd  = r_bytes_rcvd;

endmodule

// File: tb/tb_seed_key_requester.sv
// Randomized self-checking bench for seed_key_requester against a queue-based
// behavioural model of the request protocol.
module tb_seed_key_requester;

  localparam int KB = 48;
  localparam int TO = 16;
  localparam int KW = 8 * KB;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [31:0]   seed_x, seed_y, seed_z;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [KW-1:0] key;
  logic          key_valid, busy, timeout_err;
  logic [5:0]    bytes_rcvd;

  always #5 clk = ~clk;

  seed_key_requester #(.KEY_BYTES(KB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seed_x(seed_x), .seed_y(seed_y), .seed_z(seed_z),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .key(key), .key_valid(key_valid), .busy(busy),
    .timeout_err(timeout_err), .bytes_rcvd(bytes_rcvd)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending tx bytes as a queue, key as a byte array,
  // idle counter is the number of silent cycles since the last key byte.
  bit         m_busy, m_send, m_txv, m_kv, m_to;
  logic [7:0] m_txd;
  logic [7:0] q[$];
  logic [7:0] m_key[KB];
  int         m_nrx, m_idle;
  logic [7:0] acc[$];

  function automatic void model_reset();
    m_busy = 1'b0; m_send = 1'b0; m_txv = 1'b0; m_kv = 1'b0; m_to = 1'b0;
    m_txd = 8'h00; q.delete(); m_nrx = 0; m_idle = 0;
    for (int j = 0; j < KB; j++) m_key[j] = 8'h00;
  endfunction

  function automatic void model_step();
    logic [31:0] v;
    if (abort) begin
      m_busy = 1'b0; m_send = 1'b0; m_txv = 1'b0; m_kv = 1'b0; q.delete();
    end else if (start && !m_busy) begin
      q.delete();
      for (int i = 0; i < 12; i++) begin
        v = (i < 4) ? seed_x : (i < 8) ? seed_y : seed_z;
        q.push_back(8'((v >> (8 * (i % 4))) & 32'h0000_00FF));
      end
      m_txd = q[0]; m_txv = 1'b1; m_busy = 1'b1; m_send = 1'b1;
      for (int j = 0; j < KB; j++) m_key[j] = 8'h00;
      m_kv = 1'b0; m_to = 1'b0; m_nrx = 0; m_idle = 0;
    end else if (m_send) begin
      if (tx_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_txv = 1'b0; m_send = 1'b0; m_idle = 0;
        end else begin
          m_txd = q[0];
        end
      end
    end else if (m_busy) begin
      if (rx_valid) begin
        m_key[m_nrx] = rx_data;
        m_nrx++;
        m_idle = 0;
        if (m_nrx == KB) begin
          m_busy = 1'b0; m_kv = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_busy = 1'b0; m_to = 1'b1;
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic [KW-1:0] ek;
    for (int j = 0; j < KB; j++) ek[8*j +: 8] = m_key[j];
    chk("busy", KW'(busy), KW'(m_busy));
    chk("tx_valid", KW'(tx_valid), KW'(m_txv));
    chk("tx_data", KW'(tx_data), KW'(m_txd));
    chk("key_valid", KW'(key_valid), KW'(m_kv));
    chk("timeout_err", KW'(timeout_err), KW'(m_to));
    chk("bytes_rcvd", KW'(bytes_rcvd), KW'(m_nrx));
    chk("key", key, ek);
  endtask

  task automatic cyc(input logic st, input logic ab, input logic rv,
                     input logic [7:0] rd, input logic tr);
    start = st; abort = ab; rx_valid = rv; rx_data = rd; tx_ready = tr;
    if (tx_valid && tx_ready) acc.push_back(tx_data);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_all();
    for (int g = 0; g < 100 && m_send; g++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("send_done", KW'(tx_valid), KW'(1'b0));
  endtask

  task automatic check_nominal_seq(input string tag);
    logic [7:0] exp_tx[12];
    exp_tx = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
               8'hCC, 8'hBB, 8'hAA, 8'h99};
    chk({tag, "_count"}, KW'(acc.size()), KW'(12));
    for (int i = 0; i < 12 && i < acc.size(); i++)
      chk({tag, "_byte"}, KW'(acc[i]), KW'(exp_tx[i]));
  endtask

  task automatic nominal_seeds();
    seed_x = 32'h11223344; seed_y = 32'h55667788; seed_z = 32'h99AABBCC;
  endtask

  initial begin
    int quiet;
    reset = 1'b0; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_ready = 1'b0; seed_x = 32'h0; seed_y = 32'h0; seed_z = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
    // Stray traffic while idle must not start anything.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);

    // Nominal request.
    nominal_seeds();
    acc.delete();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    send_all();
    check_nominal_seq("nominal_tx");
    for (int j = 0; j < KB; j++) begin
      idle($urandom_range(0, 5));
      cyc(1'b0, 1'b0, 1'b1, 8'(j), 1'b1);
    end
    chk("key_lo", KW'(key[7:0]), KW'(8'h00));
    chk("key_hi", KW'(key[383:376]), KW'(8'h2F));
    chk("key_valid_done", KW'(key_valid), KW'(1'b1));
    idle(3);

    // Backpressure on byte 3, then 10 key bytes and a timeout.
    acc.delete();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("bp_hold", KW'(tx_data), KW'(8'h11));
    end
    send_all();
    check_nominal_seq("bp_tx");
    for (int j = 0; j < 10; j++) begin
      idle($urandom_range(0, TO - 2));
      cyc(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
    end
    idle(TO + 4);
    chk("to_err", KW'(timeout_err), KW'(1'b1));
    chk("to_bytes", KW'(bytes_rcvd), KW'(6'd10));
    chk("to_busy", KW'(busy), KW'(1'b0));

    // Stray rx in SEND, then a byte on the exact expiry cycle.
    seed_x = $urandom(); seed_y = $urandom(); seed_z = $urandom();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    send_all();
    chk("stray_key", key, '0);
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
    idle(TO - 1);
    cyc(1'b0, 1'b0, 1'b1, 8'hE7, 1'b1);
    chk("expiry_no_err", KW'(timeout_err), KW'(1'b0));
    chk("expiry_bytes", KW'(bytes_rcvd), KW'(6'd4));
    chk("expiry_key", KW'(key[31:24]), KW'(8'hE7));

    // Abort in WAIT_KEY, restart, and start while busy.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("abort_busy", KW'(busy), KW'(1'b0));
    chk("abort_bytes", KW'(bytes_rcvd), KW'(6'd4));
    nominal_seeds();
    acc.delete();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    seed_x = 32'hDEADBEEF;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    send_all();
    check_nominal_seq("restart_tx");
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("abort_start_prio", KW'(busy), KW'(1'b0));

    // Asynchronous reset while byte 6 is presented.
    nominal_seeds();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    start = 1'b0; rx_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_tx_valid", KW'(tx_valid), KW'(1'b0));
    chk("rst_tx_data", KW'(tx_data), KW'(8'h00));
    compare_all();
    @(posedge clk);
    #1 reset = 1'b1;
    idle(3);

    // Randomized traffic.
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      logic st, ab, rv, tr;
      seed_x = $urandom(); seed_y = $urandom(); seed_z = $urandom();
      st = ($urandom_range(0, 39) == 0);
      ab = ($urandom_range(0, 199) == 0);
      tr = ($urandom_range(0, 3) != 0);
      if (quiet == 0 && $urandom_range(0, 149) == 0) quiet = $urandom_range(TO - 2, TO + 2);
      if (quiet > 0) begin
        rv = 1'b0;
        quiet--;
      end else begin
        rv = ($urandom_range(0, 2) == 0);
      end
      cyc(st, ab, rv, 8'($urandom), tr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seed_key_requester.md
SEED_KEY_REQUESTER -- requirements
Module: seed_key_requester

Interface
REQ-001 Parameter KEY_BYTES, default 48: number of key bytes collected per request; key width is 8*KEY_BYTES.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle clock cycles allowed between successive key bytes.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request pulse; samples seed_x, seed_y and seed_z.
REQ-006 abort  input  1  synchronous cancel of any request in progress.
REQ-007 seed_x, seed_y, seed_z  input  32 each  chaos seeds sent to the key generator.
REQ-008 tx_data  output  8  byte presented to the byte-level UART transmitter.
REQ-009 tx_valid  output  1  tx_data holds a valid byte.
REQ-010 tx_ready  input  1  transmitter accepts the byte on an edge where tx_valid and tx_ready are both 1.
REQ-011 rx_data  input  8  byte from the byte-level UART receiver.
REQ-012 rx_valid  input  1  one-cycle strobe; rx_data is valid.
REQ-013 key  output  8*KEY_BYTES  assembled key.
REQ-014 key_valid  output  1  key is complete.
REQ-015 busy  output  1  a request is in progress.
REQ-016 timeout_err  output  1  sticky; last request timed out.
REQ-017 bytes_rcvd  output  6  key bytes received in the current request.

Function
REQ-018 States SHALL be IDLE, SEND, WAIT_KEY, DONE and ERR.
REQ-019 From IDLE, DONE or ERR, start SHALL latch the three seeds, clear key, key_valid, timeout_err and bytes_rcvd, and enter SEND; busy and tx_valid SHALL be 1 on the next cycle.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 SEND SHALL transmit 12 bytes in this order: seed_x[7:0], [15:8], [23:16], [31:24], then seed_y in the same byte order, then seed_z in the same byte order.
REQ-022 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0; the next byte SHALL be presented no earlier than the cycle after acceptance.
REQ-023 Acceptance of the 12th byte SHALL drop tx_valid on the next cycle and enter WAIT_KEY with the timeout counter at 0.
REQ-024 In WAIT_KEY, byte number j (0-based) SHALL be written to key[8*j +: 8], bytes_rcvd SHALL increment, and the timeout counter SHALL clear.
REQ-025 Byte number KEY_BYTES-1 SHALL enter DONE; key_valid SHALL be 1 on the next cycle and hold until the next start, abort or reset.
REQ-026 rx_valid SHALL be ignored in IDLE, SEND, DONE and ERR; ignored bytes SHALL NOT be written to key.
REQ-027 In WAIT_KEY, the timeout counter SHALL increment on each cycle without rx_valid; when it reaches TIMEOUT_CYCLES-1 without rx_valid, the block SHALL enter ERR with timeout_err=1 and busy=0.
REQ-028 If rx_valid arrives in the same cycle the timeout expires, the received byte SHALL take priority and no timeout SHALL occur.
REQ-029 abort in any state SHALL enter IDLE on the next cycle, drop tx_valid and busy, and clear key_valid; key, bytes_rcvd and timeout_err SHALL keep their values.
REQ-030 If abort and start are asserted in the same cycle, abort SHALL take priority.
REQ-031 busy SHALL be 1 exactly in SEND and WAIT_KEY.

Reset
REQ-032 While reset=0, the block SHALL be in IDLE with key=0, key_valid=0, busy=0, timeout_err=0, tx_valid=0, tx_data=0 and bytes_rcvd=0, including when reset is applied mid-request.
REQ-033 After reset is released, the block SHALL leave IDLE only on start.

Verification
REQ-034 Nominal request: seed_x=0x11223344, seed_y=0x55667788, seed_z=0x99AABBCC, tx_ready=1 -> tx sequence 44 33 22 11 88 77 66 55 CC BB AA 99; then rx bytes 0x00..0x2F -> key[7:0]=0x00 and key[383:376]=0x2F; key_valid=1 one cycle after the last byte.
REQ-035 Backpressure: tx_ready=0 for 5 cycles on byte 3 -> tx_data=0x11 stays stable; there is no duplicate and no skipped byte.
REQ-036 Timeout with TIMEOUT_CYCLES=16: 10 key bytes, then silence -> ERR, timeout_err=1, bytes_rcvd=10, busy=0.
REQ-037 Boundary: rx_valid on the exact expiry cycle -> byte stored and no error; stray rx_valid in SEND -> key unchanged.
REQ-038 Abort and restart: abort during WAIT_KEY, then start -> full 12-byte resend; start while busy -> no effect.
REQ-039 Mid-request reset: reset=0 during SEND byte 6 -> all outputs return to their reset values immediately (asynchronous).
